// File: rtl/md5_kt_seq.sv
// md5_kt_seq: round-robin MD5 round-constant sequencer for N_THREADS
// interleaved hash contexts. Each issue produces Kt, s and g two enabled
// cycles later, with zero pad cycles before round 0 and after round 63.
module md5_kt_seq #(
  parameter int N_THREADS = 4,
  parameter int N_PRE     = 4,
  parameter int N_POST    = 4,
  localparam int TW       = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N_THREADS-1:0] start,
  output logic [N_THREADS-1:0] ready,
  output logic                 valid_out,
  output logic [TW-1:0]        thread_out,
  output logic [31:0]          Kt,
  output logic [4:0]           s,
  output logic [3:0]           g,
  output logic                 first_out,
  output logic                 last_out
);

  localparam int N_CYCLES = N_PRE + 64 + N_POST;
  localparam int CW       = $clog2(N_CYCLES + 1);

  localparam logic [31:0] K_ROM [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // per-thread context state and slot pointer
  logic [TW-1:0]        tp_q, tp_d;
  logic [N_THREADS-1:0] busy_q, busy_d;
  logic [CW-1:0]        cnt_q [N_THREADS];
  logic [CW-1:0]        cnt_d [N_THREADS];

  // issue decode
  logic                 issue;
  logic [CW-1:0]        t_iss;
  int                   t_int;
  logic                 in_rng;
  logic [5:0]           j_c;
  logic [3:0]           jl;
  logic [4:0]           s_c;
  logic [3:0]           g_c;

  // stage 1 (constant ROM read register) and stage 2 (output register)
  logic                 v1_q, v1_d, v2_q;
  logic [TW-1:0]        th1_q, th1_d, th2_q;
  logic [31:0]          kt1_q, kt1_d, kt2_q;
  logic [4:0]           s1_q, s1_d, s2_q;
  logic [3:0]           g1_q, g1_d, g2_q;
  logic                 fi1_q, fi1_d, fi2_q;
  logic                 la1_q, la1_d, la2_q;

  // Slot advance, start acceptance and issue; starts only see busy_q, so a
  // start landing in its own slot waits for the next visit of the pointer.
  always_comb begin
    tp_d   = tp_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    issue  = 1'b0;
    t_iss  = '0;
    if (en) begin
      tp_d = (tp_q == TW'(N_THREADS - 1)) ? '0 : tp_q + 1'b1;
      for (int i = 0; i < N_THREADS; i++) begin
        if (start[i] && !busy_q[i]) begin
          busy_d[i] = 1'b1;
          cnt_d[i]  = '0;
        end
      end
      if (busy_q[tp_q]) begin
        issue = 1'b1;
        t_iss = cnt_q[tp_q];
        if (cnt_q[tp_q] == CW'(N_CYCLES - 1)) begin
          busy_d[tp_q] = 1'b0;
          cnt_d[tp_q]  = '0;
        end else begin
          cnt_d[tp_q] = cnt_q[tp_q] + 1'b1;
        end
      end
    end
  end

  assign t_int  = int'(t_iss);
  assign in_rng = (t_int >= N_PRE) && (t_int < N_PRE + 64);
  assign j_c    = 6'(t_int - N_PRE);
  assign jl     = j_c[3:0];

  // Rotate amount and message word index for round j (4-bit math wraps mod 16)
  always_comb begin
    s_c = '0;
    g_c = '0;
    if (in_rng) begin
      case ({j_c[5:4], j_c[1:0]})
        4'h0: s_c = 5'd7;   4'h1: s_c = 5'd12;  4'h2: s_c = 5'd17;  4'h3: s_c = 5'd22;
        4'h4: s_c = 5'd5;   4'h5: s_c = 5'd9;   4'h6: s_c = 5'd14;  4'h7: s_c = 5'd20;
        4'h8: s_c = 5'd4;   4'h9: s_c = 5'd11;  4'ha: s_c = 5'd16;  4'hb: s_c = 5'd23;
        4'hc: s_c = 5'd6;   4'hd: s_c = 5'd10;  4'he: s_c = 5'd15;  default: s_c = 5'd21;
      endcase
      case (j_c[5:4])
        2'd0:    g_c = jl;
        2'd1:    g_c = (jl << 2) + jl + 4'd1;
        2'd2:    g_c = (jl << 1) + jl + 4'd5;
        default: g_c = (jl << 3) - jl;
      endcase
    end
  end

  // Stage 1 next values; idle slots carry all-zero data
  always_comb begin
    v1_d  = issue;
    th1_d = issue ? tp_q : '0;
    kt1_d = (issue && in_rng) ? K_ROM[j_c] : '0;
    s1_d  = issue ? s_c : '0;
    g1_d  = issue ? g_c : '0;
    fi1_d = issue && (t_int == N_PRE);
    la1_d = issue && (t_int == N_CYCLES - 1);
  end

  // Context state registers
  always_ff @(posedge CLK) begin
    if (rst) begin
      tp_q   <= '0;
      busy_q <= '0;
      for (int i = 0; i < N_THREADS; i++) cnt_q[i] <= '0;
    end else begin
      tp_q   <= tp_d;
      busy_q <= busy_d;
      for (int i = 0; i < N_THREADS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Stage 1: registered constant read plus s/g/sideband
  always_ff @(posedge CLK) begin
    if (rst) begin
      v1_q  <= 1'b0;
      th1_q <= '0;
      kt1_q <= '0;
      s1_q  <= '0;
      g1_q  <= '0;
      fi1_q <= 1'b0;
      la1_q <= 1'b0;
    end else if (en) begin
      v1_q  <= v1_d;
      th1_q <= th1_d;
      kt1_q <= kt1_d;
      s1_q  <= s1_d;
      g1_q  <= g1_d;
      fi1_q <= fi1_d;
      la1_q <= la1_d;
    end
  end

  // Stage 2: fabric output register, kept apart from the ROM read register
  always_ff @(posedge CLK) begin
    if (rst) begin
      v2_q  <= 1'b0;
      th2_q <= '0;
      kt2_q <= '0;
      s2_q  <= '0;
      g2_q  <= '0;
      fi2_q <= 1'b0;
      la2_q <= 1'b0;
    end else if (en) begin
      v2_q  <= v1_q;
      th2_q <= th1_q;
      kt2_q <= kt1_q;
      s2_q  <= s1_q;
      g2_q  <= g1_q;
      fi2_q <= fi1_q;
      la2_q <= la1_q;
    end
  end

  assign ready      = ~busy_q;
  assign valid_out  = v2_q;
  assign thread_out = th2_q;
  assign Kt         = kt2_q;
  assign s          = s2_q;
  assign g          = g2_q;
  assign first_out  = fi2_q;
  assign last_out   = la2_q;

endmodule

// File: doc/md5_kt_seq.md
Name: md5_kt_seq

Overview:
- Multi-thread MD5 round-constant sequencer; generalises the per-round Kt ROM into a self-counting block.
- Serves N_THREADS interleaved hash contexts round-robin, one slot per enabled cycle.
- Per issued round it outputs the additive constant Kt, the rotate amount s and the message word index g.
- Leading and trailing zero-pad cycle counts are set by parameters.
- Sits beside the md5core datapath and replaces its external round counter plus Kt ROM.

Parameters:
- N_THREADS, 4: number of interleaved contexts, 1..16.
- N_PRE, 4: zero-constant cycles before round 0.
- N_POST, 4: zero-constant cycles after round 63.
- N_CYCLES (localparam) = N_PRE+64+N_POST: issues per thread per block.

Ports:
- CLK  in  1  clock; the block uses this single clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  global advance enable; when 0 all state holds.
- start  in  N_THREADS  per-thread start request.
- ready  out  N_THREADS  thread i idle; registered ~busy[i].
- valid_out  out  1  output word valid.
- thread_out  out  `MSB(N_THREADS-1)+1  thread the output belongs to.
- Kt  out  32  MD5 constant, or 0 in pad cycles.
- s  out  5  rotate amount, or 0 in pad cycles.
- g  out  4  message word index, or 0 in pad cycles.
- first_out  out  1  output is round 0 (t==N_PRE).
- last_out  out  1  output is the final issue (t==N_CYCLES-1).

Behaviour:
- Reset: all outputs 0, ready all 1, busy 0, all cnt 0, slot pointer tp=0. Applies mid-run: all threads abort and the pipeline is flushed. valid_out is 0 in the cycle after rst is sampled.
- en=0: tp, cnt, busy and both pipeline stages hold; start is ignored.
- Slot pointer (when en): tp wraps N_THREADS-1 -> 0, otherwise tp+1.
- Start (when en): start[i] with busy[i]=0 sets busy[i]=1 and cnt[i]=0. start[i] while busy[i]=1 is ignored, with no queuing.
- Start landing in thread i's own slot does not issue that cycle. The first issue happens at the next occurrence of tp==i.
- Issue (when en, tp==i, busy[i]=1): t=cnt[i] enters stage 1 and cnt[i] increments.
- When t==N_CYCLES-1: busy[i]=0 and cnt[i]=0 at the next edge.
- A start[i] in that same final-issue cycle is ignored, because ready[i] is still 0.
- Constant mapping for t<N_PRE or t>=N_PRE+64: Kt=s=g=0.
- Otherwise j=t-N_PRE and Kt = standard MD5 K[j] (K[0]=d76aa478 ... K[63]=eb86d391).
- s: round0 {7,12,17,22}, round1 {5,9,14,20}, round2 {4,11,16,23}, round3 {6,10,15,21}, indexed by j%4.
- g: round0 j; round1 (5j+1)%16; round2 (3j+5)%16; round3 (7j)%16.
- Storage: Kt in block RAM with registered read (stage 1). s and g are computed combinationally from t and registered in stage 1.
- Stage 2: separate fabric output register, not the BRAM output reg. Both stages are en-gated and rst-cleared.
- Latency: 2 enabled cycles from issue to output. valid_out, thread_out, first_out and last_out travel alongside the data.
- Slot with no issue (thread idle): valid_out=0 and data outputs forced to 0.
- Throughput: each thread issues once per N_THREADS enabled cycles.
- Block time: N_CYCLES*N_THREADS enabled cycles.

Test Plan:
- Issue timing (N_THREADS=1, N_PRE=4, start at cycle 0, en=1): first issue at cycle 1. Output at cycle 3: valid=1, Kt=0. Output at cycle 7: Kt=d76aa478, s=7, g=0, first_out=1.
- Round spot checks: j=1 -> e8c7b756/12/1; j=16 -> f61e2562/5/1; j=32 -> fffa3942/4/5; j=48 -> f4292244/6/0.
- Final issue: j=63 -> eb86d391/21/9. last_out=1 at cycle 74 with Kt=0; ready=1 from cycle 73. start held high through cycle 72 is ignored and only restarts the thread after ready rises.
- Interleave (N_THREADS=4, start[2] then start[0] two cycles later): thread_out alternates 2,0 with idle gaps. Each thread's Kt sequence is independent and correct.
- Stall: en toggled 0/1 randomly mid-run. The output sequence equals the en=1 run with the stalled cycles removed, and no start is accepted while en=0.
- Reset mid-run: rst at t=30. valid_out=0 next cycle and ready all 1. A new start replays from t=0.
